// File: rtl/logic_gate_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_pipe_if
// Description : Operand/result handshake bundle for logic_gate_pipe.
//               master : the side that offers operands and takes results
//                        (drives in_valid, in_a, in_b, in_op, sweep_start,
//                        out_ready).
//               slave  : the logic_gate_pipe block itself (drives in_ready,
//                        sweep_busy, out_valid, out_y, out_zero, out_last).
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_gate_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_op;
   logic             sweep_start;
   logic             sweep_busy;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   logic             out_zero;
   logic             out_last;

   modport master (
      output in_valid, in_a, in_b, in_op, sweep_start, out_ready,
      input  in_ready, sweep_busy, out_valid, out_y, out_zero, out_last
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, sweep_start, out_ready,
      output in_ready, sweep_busy, out_valid, out_y, out_zero, out_last
   );
endinterface
`default_nettype wire

// File: rtl/logic_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_pipe
// Description : Single-stage bitwise logic unit with valid/ready handshake
//               and a built-in exhaustive self-sweep over all operand pairs
//               formed from a SWEEP_BITS-wide vector counter.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - logic_gate_pipe_if.slave (operand beat in, result out,
//                      sweep_start / sweep_busy control)
// Parameters  : WIDTH      - operand/result width, 1..32
//               SWEEP_BITS - sweep counter width, even, 2..16, <= 2*WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_pipe #(
   parameter int WIDTH      = 8,
   parameter int SWEEP_BITS = 4
) (
   input  logic               clk,
   input  logic               rst,
   logic_gate_pipe_if.slave   bus
);

   localparam int c_HALF = SWEEP_BITS / 2;

   localparam logic [0:0] c_ST_IDLE  = 1'b0;
   localparam logic [0:0] c_ST_SWEEP = 1'b1;

   localparam logic [SWEEP_BITS-1:0] c_K_ONE  = {{(SWEEP_BITS-1){1'b0}}, 1'b1};
   localparam logic [SWEEP_BITS-1:0] c_K_LAST = {SWEEP_BITS{1'b1}};

   logic [0:0]            r_state;
   logic [0:0]            w_state_nxt;
   logic [SWEEP_BITS-1:0] r_k;
   logic [2:0]            r_op;
   logic [WIDTH-1:0]      r_y;
   logic                  r_zero;
   logic                  r_last;
   logic                  r_valid;

   logic                  w_load_en;
   logic                  w_in_ready;
   logic                  w_busy;
   logic                  w_sweep_load;
   logic                  w_accept;
   logic                  w_k_last;
   logic [WIDTH-1:0]      w_a;
   logic [WIDTH-1:0]      w_b;
   logic [2:0]            w_op;
   logic [WIDTH-1:0]      w_res;

   // The single output register can take a new value when empty or when
   // its current content is being consumed this cycle.
   assign w_load_en = !r_valid || bus.out_ready;
   assign w_k_last  = (r_k == c_K_LAST);
   assign w_accept  = bus.in_valid && w_in_ready;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:  if (bus.sweep_start) w_state_nxt = c_ST_SWEEP;
         c_ST_SWEEP: if (w_load_en && w_k_last) w_state_nxt = c_ST_IDLE;
         default:    w_state_nxt = c_ST_IDLE;
      endcase
   end

   // sweep_start wins over an external beat, so in_ready is masked by it.
   always_comb begin
      w_in_ready   = 1'b0;
      w_busy       = 1'b0;
      w_sweep_load = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            w_in_ready = w_load_en && !bus.sweep_start;
         end
         c_ST_SWEEP: begin
            w_busy       = 1'b1;
            w_sweep_load = w_load_en;
         end
         default: begin
            w_in_ready = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------ operand select
   // During a sweep the low half of k is A and the high half is B, both
   // zero-extended to WIDTH; the external operands are ignored.
   always_comb begin
      w_a  = '0;
      w_b  = '0;
      w_op = bus.in_op;
      if (w_busy) begin
         w_a[c_HALF-1:0] = r_k[c_HALF-1:0];
         w_b[c_HALF-1:0] = r_k[SWEEP_BITS-1:c_HALF];
         w_op            = r_op;
      end else begin
         w_a = bus.in_a;
         w_b = bus.in_b;
      end
   end

   always_comb begin
      w_res = '0;
      case (w_op)
         3'b000:  w_res = w_a & w_b;
         3'b001:  w_res = w_a | w_b;
         3'b010:  w_res = w_a ^ w_b;
         3'b011:  w_res = ~(w_a & w_b);
         3'b100:  w_res = ~(w_a | w_b);
         3'b101:  w_res = ~(w_a ^ w_b);
         3'b110:  w_res = w_a & ~w_b;
         default: w_res = w_a;
      endcase
   end

   // --------------------------------------------------- sweep sequencing
   // k stops at its final value rather than wrapping; the next sweep_start
   // clears it again.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_k  <= '0;
         r_op <= 3'b000;
      end else if ((r_state == c_ST_IDLE) && bus.sweep_start) begin
         r_k  <= '0;
         r_op <= bus.in_op;
      end else if (w_sweep_load && !w_k_last) begin
         r_k  <= r_k + c_K_ONE;
      end
   end

   // ---------------------------------------------------- output register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_y     <= '0;
         r_zero  <= 1'b0;
         r_last  <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_y     <= w_res;
         r_zero  <= (w_res == '0);
         r_last  <= 1'b0;
      end else if (w_sweep_load) begin
         r_valid <= 1'b1;
         r_y     <= w_res;
         r_zero  <= (w_res == '0);
         r_last  <= w_k_last;
      end else if (bus.out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.sweep_busy = w_busy;
   assign bus.out_valid  = r_valid;
   assign bus.out_y      = r_y;
   assign bus.out_zero   = r_zero;
   assign bus.out_last   = r_last;

endmodule
`default_nettype wire
